sample_readout: RTL and testbench
=================================

SAMPLE_READOUT -- requirements
Module: sample_readout

Interface
REQ-001 The module SHALL have parameter ram_width, default 10, giving the sample RAM address width (RAM depth 2^ram_width).
REQ-002 Port clk, input, 1: the single clock, the same domain as data_ready and the sample RAM read port.
REQ-003 Port reset, input, 1: asynchronous, active-high reset.
REQ-004 Port readstart, input, 1: single-cycle request to read out one acquisition.
REQ-005 Port abort, input, 1: single-cycle request to cancel a readout in progress.
REQ-006 Port autorearm, input, 1: when 1, pulse startTrigger at the end of a readout.
REQ-007 Port data_ready, input, 1: acquisition complete flag from the acquisition block.
REQ-008 Port wraddress_triggerpoint, input, ram_width: RAM address at which the trigger occurred.
REQ-009 Port triggerpoint, input, ram_width: number of pre-trigger samples.
REQ-010 Port readlength, input, ram_width+1: number of bytes to send, valid range 0..2^ram_width.
REQ-011 Port rden, output, 1: RAM read enable.
REQ-012 Port rdaddress, output, ram_width: RAM read address.
REQ-013 Port ram_q, input, 8: RAM read data, valid exactly one clk after the rden cycle.
REQ-014 Port tx_data, output, 8: byte to the serial/USB transmitter.
REQ-015 Port tx_valid, output, 1: tx_data is valid.
REQ-016 Port tx_ready, input, 1: the transmitter accepts the byte when tx_valid and tx_ready are both 1 at a clk edge.
REQ-017 Port busy, output, 1: high in any state other than IDLE.
REQ-018 Port done, output, 1: one-cycle pulse when a readout ends normally.
REQ-019 Port startTrigger, output, 1: one-cycle rearm pulse to the acquisition block.

Function
REQ-020 The state machine SHALL have the states IDLE, WAITRDY, READ, WAITQ, SEND and FIN.
REQ-021 In IDLE, when readstart=1, the module SHALL latch readlength into len_r and compute addr_r = (wraddress_triggerpoint - triggerpoint) mod 2^ram_width.
REQ-022 On that same readstart, the module SHALL clear the byte counter cnt and go to WAITRDY.
REQ-023 readstart outside IDLE SHALL be ignored.
REQ-024 In WAITRDY, the module SHALL go to FIN if len_r==0; otherwise to READ when data_ready=1; otherwise it SHALL stay in WAITRDY.
REQ-025 In READ, the module SHALL drive rden=1 and rdaddress=addr_r for exactly one cycle, then go to WAITQ.
REQ-026 In WAITQ, the module SHALL register ram_q into tx_data, set tx_valid=1 and go to SEND.
REQ-027 In SEND, tx_valid SHALL be held high and tx_data SHALL be held stable until a handshake completes.
REQ-028 On the SEND handshake, the module SHALL clear tx_valid, set addr_r to addr_r+1 with wrap from 2^ram_width-1 to 0, and set cnt to cnt+1.
REQ-029 After the SEND handshake, the module SHALL go to FIN if cnt+1==len_r, else to READ.
REQ-030 Minimum throughput SHALL be one byte per 3 clk cycles when tx_ready is held at 1.
REQ-031 In FIN, the module SHALL pulse done=1 for one cycle and pulse startTrigger=1 in that same cycle iff autorearm=1, then return to IDLE.
REQ-032 When abort=1 in any state other than IDLE, the module SHALL return to IDLE on the next edge with tx_valid=0, rden=0, and no done or startTrigger pulse.
REQ-033 abort SHALL take priority over every other transition, including a handshake in the same cycle; that byte SHALL not be counted.
REQ-034 rden SHALL be 0 outside READ.
REQ-035 rdaddress SHALL hold its last value outside READ.
REQ-036 The arithmetic for cnt and len_r SHALL be ram_width+1 bits wide, so that readlength=2^ram_width sends the whole RAM exactly once.
REQ-037 A data_ready drop during READ, WAITQ or SEND SHALL not affect the readout.

Reset
REQ-038 When reset=1, the module SHALL asynchronously force state=IDLE, with rden, tx_valid, busy, done and startTrigger at 0.
REQ-039 When reset=1, the module SHALL asynchronously force tx_data, rdaddress, addr_r, cnt and len_r to 0.
REQ-040 Reset asserted mid-readout SHALL abandon the readout with no done pulse.
REQ-041 After reset deassertion, the module SHALL wait for a new readstart.

Verification
REQ-042 Basic readout: wraddress_triggerpoint=100, triggerpoint=40, readlength=4, data_ready=1, tx_ready=1, readstart -> rdaddress sequence 60, 61, 62, 63; 4 handshakes with the RAM contents; one done pulse; busy falls the cycle after done.
REQ-043 Wrap-around: wraddress_triggerpoint=5, triggerpoint=10, readlength=8 -> rdaddress 1019..1023 then 0, 1, 2.
REQ-044 Full RAM: readlength=1024 -> exactly 1024 bytes, every address sent once, done once.
REQ-045 Backpressure: tx_ready low for 7 cycles while tx_valid=1 -> tx_data stable, no new rden, byte accepted once tx_ready rises.
REQ-046 Wait and zero-length: readstart with data_ready=0 -> module stays in WAITRDY with no rden until data_ready=1; readlength=0 -> done 2 cycles after readstart with no tx_valid; autorearm=1 -> startTrigger coincident with done.
REQ-047 Abort and reset: abort during the 3rd SEND, coincident with tx_ready=1 -> IDLE, 2 bytes counted, no done; reset asserted in WAITQ -> all outputs 0 immediately, with no clk edge needed.

Source files
------------

// File: rtl/sample_readout.sv
// Reads one acquisition out of the sample RAM, starting at the pre-trigger point, and streams
// it byte by byte to a ready/valid transmitter.
module sample_readout #(
  parameter int unsigned ram_width = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 readstart,
  input  logic                 abort,
  input  logic                 autorearm,
  input  logic                 data_ready,
  input  logic [ram_width-1:0] wraddress_triggerpoint,
  input  logic [ram_width-1:0] triggerpoint,
  input  logic [ram_width:0]   readlength,
  output logic                 rden,
  output logic [ram_width-1:0] rdaddress,
  input  logic [7:0]           ram_q,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 startTrigger
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitRdy,
    StRead,
    StWaitQ,
    StSend,
    StFin
  } state_e;

  state_e               state_q, state_d;
  logic [ram_width-1:0] addr_q, addr_d;
  logic [ram_width-1:0] rdaddr_q, rdaddr_d;
  logic [ram_width:0]   len_q, len_d;
  logic [ram_width:0]   cnt_q, cnt_d;
  logic [ram_width:0]   cnt_inc;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 handshake;

  assign handshake = tx_valid_q & tx_ready;
  // Counter and length are one bit wider than the address so a full-RAM readout terminates.
  assign cnt_inc   = cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rdaddr_d   = rdaddr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;

    if (abort && (state_q != StIdle)) begin
      // Abort wins over everything, including a handshake in the same cycle.
      state_d    = StIdle;
      tx_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (readstart) begin
            len_d   = readlength;
            addr_d  = wraddress_triggerpoint - triggerpoint;
            cnt_d   = '0;
            state_d = StWaitRdy;
          end
        end
        StWaitRdy: begin
          if (len_q == '0) begin
            state_d = StFin;
          end else if (data_ready) begin
            state_d = StRead;
          end
        end
        StRead: begin
          rdaddr_d = addr_q;
          state_d  = StWaitQ;
        end
        StWaitQ: begin
          tx_data_d  = ram_q;
          tx_valid_d = 1'b1;
          state_d    = StSend;
        end
        StSend: begin
          if (handshake) begin
            tx_valid_d = 1'b0;
            addr_d     = addr_q + 1'b1;
            cnt_d      = cnt_inc;
            state_d    = (cnt_inc == len_q) ? StFin : StRead;
          end
        end
        StFin: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      rdaddr_q   <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rdaddr_q   <= rdaddr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  // Address is live in READ and holds its last value elsewhere.
  assign rden         = (state_q == StRead);
  assign rdaddress    = rden ? addr_q : rdaddr_q;
  assign tx_data      = tx_data_q;
  assign tx_valid     = tx_valid_q;
  assign busy         = (state_q != StIdle);
  assign done         = (state_q == StFin) && !abort;
  assign startTrigger = done && autorearm;

endmodule

// File: tb/tb_sample_readout.sv
// Self-checking bench for sample_readout: table of readouts checked against an address/byte
// model built from the trigger arithmetic, plus hand-written backpressure, abort and reset cases.
module tb_sample_readout;

  localparam int unsigned RW    = 10;
  localparam int unsigned DEPTH = 1 << RW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          readstart = 1'b0;
  logic          abort = 1'b0;
  logic          autorearm = 1'b0;
  logic          data_ready = 1'b0;
  logic          tx_ready = 1'b0;
  logic [RW-1:0] wtp = '0;
  logic [RW-1:0] tp = '0;
  logic [RW:0]   readlength = '0;
  logic          rden;
  logic [RW-1:0] rdaddress;
  logic [7:0]    ram_q = '0;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          busy;
  logic          done;
  logic          start_trigger;

  logic [7:0]    mem [DEPTH];

  int errors = 0;
  int checks = 0;

  int         addr_seen[$];
  logic [7:0] byte_seen[$];
  int         done_seen, st_seen, st_stray, tv_seen;

  typedef struct {
    int w;
    int t;
    int l;
    int a;
    int bp;
    int exp_start;
  } vec_t;
  vec_t vecs[$];

  sample_readout #(.ram_width(RW)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .readstart             (readstart),
    .abort                 (abort),
    .autorearm             (autorearm),
    .data_ready            (data_ready),
    .wraddress_triggerpoint(wtp),
    .triggerpoint          (tp),
    .readlength            (readlength),
    .rden                  (rden),
    .rdaddress             (rdaddress),
    .ram_q                 (ram_q),
    .tx_data               (tx_data),
    .tx_valid              (tx_valid),
    .tx_ready              (tx_ready),
    .busy                  (busy),
    .done                  (done),
    .startTrigger          (start_trigger)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM: data one clock after rden.
  always @(posedge clk) begin
    if (rden) ram_q <= mem[rdaddress];
  end

  // Inputs only change just after a rising edge, so the falling edge sees what the next
  // rising edge will act on.
  always @(negedge clk) begin
    if (!reset) begin
      if (rden) addr_seen.push_back(int'(rdaddress));
      if (tx_valid) tv_seen++;
      if (tx_valid && tx_ready && !abort) byte_seen.push_back(tx_data);
      if (done) done_seen++;
      if (start_trigger) begin
        st_seen++;
        if (!done) st_stray++;
      end
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    addr_seen.delete();
    byte_seen.delete();
    done_seen = 0;
    st_seen   = 0;
    st_stray  = 0;
    tv_seen   = 0;
  endtask

  task automatic start(input int w, input int t, input int l, input int a);
    wtp        = w[RW-1:0];
    tp         = t[RW-1:0];
    readlength = l[RW:0];
    autorearm  = a[0];
    readstart  = 1'b1;
    tick();
    readstart  = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit bp, output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    while (!ok && cyc < budget) begin
      if (bp) begin
        tx_ready   = ($urandom_range(0, 2) != 0);
        data_ready = ($urandom_range(0, 3) != 0);
      end
      tick();
      cyc++;
      if (done) ok = 1'b1;
    end
  endtask

  task automatic recover();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
  endtask

  // Expected stream: address (trigger - pretrigger + i) mod depth, byte = RAM contents there.
  task automatic compare_model(input string tag, input int w, input int t, input int l);
    int amis;
    int bmis;
    int ea;
    amis = 0;
    bmis = 0;
    check({tag, " rden count"}, addr_seen.size(), l);
    check({tag, " byte count"}, byte_seen.size(), l);
    for (int i = 0; i < l; i++) begin
      ea = (w - t + i) & (DEPTH - 1);
      if (i < addr_seen.size() && addr_seen[i] != ea) amis++;
      if (i < byte_seen.size() && byte_seen[i] != mem[ea]) bmis++;
    end
    check({tag, " addr mismatches"}, amis, 0);
    check({tag, " byte mismatches"}, bmis, 0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int cyc;
    bit ok;
    clear_mon();
    data_ready = 1'b1;
    tx_ready   = 1'b1;
    start(v.w, v.t, v.l, v.a);
    wait_done(40 * v.l + 50, v.bp[0], cyc, ok);
    check({tag, " finished"}, int'(ok), 1);
    if (!ok) begin
      recover();
    end else begin
      check({tag, " startTrigger with done"}, int'(start_trigger), v.a);
      if (v.bp == 0) check({tag, " within 3 cycles/byte"}, int'(cyc <= 1 + 3 * v.l), 1);
      tick();
      check({tag, " busy after done"}, int'(busy), 0);
      check({tag, " done one cycle"}, int'(done), 0);
    end
    compare_model(tag, v.w, v.t, v.l);
    check({tag, " first addr"}, (addr_seen.size() > 0) ? addr_seen[0] : -1,
          (v.l > 0) ? v.exp_start : -1);
    check({tag, " done pulses"}, done_seen, 1);
    check({tag, " startTrigger pulses"}, st_seen, v.a);
    check({tag, " stray startTrigger"}, st_stray, 0);
    if (v.l == 0) check({tag, " no tx_valid"}, tv_seen, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   k;
    int   cnt;
    int   rd;
    int   cyc;
    bit   ok;
    logic [7:0] held;

    for (int i = 0; i < int'(DEPTH); i++) mem[i] = 8'($urandom);

    repeat (3) @(posedge clk);
    #1;
    check("reset rden", int'(rden), 0);
    check("reset rdaddress", int'(rdaddress), 0);
    check("reset tx_data", int'(tx_data), 0);
    check("reset tx_valid", int'(tx_valid), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset startTrigger", int'(start_trigger), 0);
    reset = 1'b0;
    repeat (3) tick();
    check("idle without readstart", int'(busy), 0);

    // Fixed vectors: basic, wrap-around, full RAM (two ways), single byte, zero length.
    vecs.push_back('{100, 40, 4, 0, 0, 60});
    vecs.push_back('{5, 10, 8, 1, 0, 1019});
    vecs.push_back('{0, 0, 1024, 0, 0, 0});
    vecs.push_back('{300, 7, 1024, 1, 1, 293});
    vecs.push_back('{1023, 1023, 1, 0, 1, 0});
    vecs.push_back('{10, 20, 0, 1, 0, 1014});
    for (int i = 0; i < 8; i++) begin
      vec_t v;
      v.w  = int'($urandom_range(0, DEPTH - 1));
      v.t  = int'($urandom_range(0, DEPTH - 1));
      v.l  = int'($urandom_range(1, 40));
      v.a  = int'($urandom_range(0, 1));
      v.bp = 1;
      v.exp_start = (v.w - v.t) & (DEPTH - 1);
      vecs.push_back(v);
    end
    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: byte held for 7 cycles with tx_ready low.
    clear_mon();
    data_ready = 1'b1;
    tx_ready   = 1'b0;
    start(200, 0, 4, 0);
    k = 0;
    while (!tx_valid && k < 20) begin
      tick();
      k++;
    end
    check("bp tx_valid raised", int'(tx_valid), 1);
    held = tx_data;
    cnt  = 0;
    rd   = 0;
    repeat (7) begin
      tick();
      if (tx_data != held || !tx_valid) cnt++;
      if (rden) rd++;
    end
    check("bp data stable", cnt, 0);
    check("bp no rden", rd, 0);
    check("bp nothing accepted", byte_seen.size(), 0);
    tx_ready = 1'b1;
    tick();
    check("bp accepted on ready", byte_seen.size(), 1);
    check("bp first byte", (byte_seen.size() > 0) ? int'(byte_seen[0]) : -1, int'(mem[200]));
    wait_done(60, 1'b0, cyc, ok);
    check("bp finished", int'(ok), 1);
    if (!ok) recover();
    else tick();
    compare_model("bp", 200, 0, 4);

    // Waiting on data_ready.
    clear_mon();
    data_ready = 1'b0;
    tx_ready   = 1'b1;
    start(50, 10, 2, 0);
    rd = 0;
    repeat (10) begin
      tick();
      if (rden) rd++;
    end
    check("waitrdy no rden", rd, 0);
    check("waitrdy busy", int'(busy), 1);
    data_ready = 1'b1;
    wait_done(40, 1'b0, cyc, ok);
    check("waitrdy finished", int'(ok), 1);
    if (!ok) recover();
    else tick();
    compare_model("waitrdy", 50, 10, 2);

    // Zero length with autorearm: done two cycles after readstart.
    clear_mon();
    start(0, 0, 0, 1);
    check("zero busy", int'(busy), 1);
    check("zero done early", int'(done), 0);
    tick();
    check("zero done", int'(done), 1);
    check("zero startTrigger", int'(start_trigger), 1);
    tick();
    check("zero back idle", int'(busy), 0);
    check("zero no tx_valid", tv_seen, 0);

    // Abort coincident with the third byte's handshake.
    clear_mon();
    data_ready = 1'b1;
    tx_ready   = 1'b1;
    start(400, 0, 8, 1);
    cnt = 0;
    k   = 0;
    while (k < 60 && cnt < 3) begin
      tick();
      k++;
      if (tx_valid) cnt++;
    end
    check("abort reached 3rd send", cnt, 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort idle", int'(busy), 0);
    check("abort tx_valid", int'(tx_valid), 0);
    check("abort rden", int'(rden), 0);
    repeat (5) tick();
    check("abort bytes", byte_seen.size(), 2);
    check("abort byte0", (byte_seen.size() > 0) ? int'(byte_seen[0]) : -1, int'(mem[400]));
    check("abort byte1", (byte_seen.size() > 1) ? int'(byte_seen[1]) : -1, int'(mem[401]));
    check("abort no done", done_seen, 0);
    check("abort no startTrigger", st_seen, 0);
    check("abort stays idle", int'(busy), 0);

    // Asynchronous reset while in WAITQ of the second byte.
    mem[500] = 8'h5a;
    mem[501] = 8'hc3;
    clear_mon();
    start(500, 0, 4, 0);
    cnt = 0;
    k   = 0;
    while (k < 40 && cnt < 2) begin
      tick();
      k++;
      if (rden) cnt++;
    end
    check("rst reached 2nd read", cnt, 2);
    tick();
    check("rst pre tx_data", int'(tx_data), 8'h5a);
    check("rst pre rdaddress", int'(rdaddress), 501);
    #2;
    reset = 1'b1;
    #1;
    check("rst async rden", int'(rden), 0);
    check("rst async rdaddress", int'(rdaddress), 0);
    check("rst async tx_data", int'(tx_data), 0);
    check("rst async tx_valid", int'(tx_valid), 0);
    check("rst async busy", int'(busy), 0);
    check("rst async done", int'(done), 0);
    check("rst async startTrigger", int'(start_trigger), 0);
    tick();
    reset = 1'b0;
    repeat (5) tick();
    check("rst stays idle", int'(busy), 0);
    check("rst no done", done_seen, 0);

    run_vec('{10, 3, 5, 1, 1, 7}, "post-reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
